// File: rtl/filter_ctrl_if.sv
`default_nettype none
// ============================================================
// filter_ctrl_if : handshake bundle between the frame sequencer
// and the top-level / memory / preprocess side.   Rev 1.0
// ============================================================
interface filter_ctrl_if #(
  parameter int ROW_W = 10
);
  logic             start_i;
  logic             abort_i;
  logic             mem_valid_i;
  logic             mem_req_o;
  logic             fetch_en_o;
  logic             fetch_done_i;
  logic             core_en_o;
  logic             core_done_i;
  logic [ROW_W-1:0] row_idx_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    input  start_i, abort_i, mem_valid_i, fetch_done_i, core_done_i,
    output mem_req_o, fetch_en_o, core_en_o, row_idx_o, busy_o, done_o, err_o
  );

  modport slave (
    output start_i, abort_i, mem_valid_i, fetch_done_i, core_done_i,
    input  mem_req_o, fetch_en_o, core_en_o, row_idx_o, busy_o, done_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/filter_ctrl.sv
`default_nettype none
// ============================================================
// filter_ctrl : frame sequencer for the 3x3 line-buffer stage.
// Optional fetch-stall timeout: FILTER_CTRL_TIMEOUT_EN. Rev 1.0
// ============================================================
module filter_ctrl #(
  parameter int IMG_COLS    = 540,
  parameter int IMG_ROWS    = 960,
  parameter int ROW_W       = 10,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst,
  filter_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    COMPUTE = 3'd2,
    NEXT    = 3'd3,
    DONE    = 3'd4
`ifdef FILTER_CTRL_TIMEOUT_EN
    , ERR   = 3'd5
`endif
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 3);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             fetch_en;

  // Column count is enforced by preprocess through core_done_i.
  logic unused_cfg;
  assign unused_cfg = ^{32'(IMG_COLS), 32'(TIMEOUT_CYC)};

`ifdef FILTER_CTRL_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  assign fetch_en = (state_q == FETCH) && bus.mem_valid_i;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
`ifdef FILTER_CTRL_TIMEOUT_EN
    err_d    = err_q;
    to_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = FETCH;
          row_d   = '0;
`ifdef FILTER_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (bus.fetch_done_i && fetch_en) begin
          state_d = COMPUTE;
`ifdef FILTER_CTRL_TIMEOUT_EN
        end else if (!bus.mem_valid_i) begin
          // Counter only survives consecutive stall cycles.
          if (to_cnt_q == TO_LAST) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      COMPUTE: begin
        if (bus.core_done_i) state_d = NEXT;
      end
      NEXT: begin
        if (row_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          row_d   = row_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
`ifdef FILTER_CTRL_TIMEOUT_EN
      ERR:  state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a start seen in IDLE.
    if (bus.abort_i) begin
      state_d = IDLE;
      row_d   = (state_q == IDLE) ? row_q : '0;
`ifdef FILTER_CTRL_TIMEOUT_EN
      err_d    = err_q;
      to_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
`ifdef FILTER_CTRL_TIMEOUT_EN
      err_q    <= 1'b0;
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
`ifdef FILTER_CTRL_TIMEOUT_EN
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign bus.mem_req_o  = (state_q == FETCH);
  assign bus.fetch_en_o = fetch_en;
  assign bus.core_en_o  = (state_q == COMPUTE);
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = (state_q == DONE);
  assign bus.row_idx_o  = row_q;
`ifdef FILTER_CTRL_TIMEOUT_EN
  assign bus.err_o      = err_q;
`else
  assign bus.err_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_filter_ctrl.sv
`default_nettype none
// ============================================================
// tb_filter_ctrl : randomized self-checking bench for filter_ctrl
// against a per-cycle expected schedule.                Rev 1.0
// ============================================================
module tb_filter_ctrl;

  localparam int C    = 4;
  localparam int R    = 5;
  localparam int RW   = 4;
  localparam int TO   = 8;
  localparam int NP   = R - 2;
  localparam int OW   = RW + 6;
  localparam int MAXC = 512;

  logic clk;
  logic rst;
  logic pp_clr;
  int   checks;
  int   errors;

  filter_ctrl_if #(.ROW_W(RW)) bus ();

  filter_ctrl #(
    .IMG_COLS(C), .IMG_ROWS(R), .ROW_W(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the preprocess counters: 3 rows of fetch, one row of core.
  int fcnt, ccnt;
  always @(posedge clk or posedge rst) begin
    if (rst || pp_clr) begin
      fcnt <= 0;
      ccnt <= 0;
    end else begin
      if (bus.fetch_en_o) fcnt <= (fcnt == 3*C-1) ? 0 : fcnt + 1;
      if (bus.core_en_o)  ccnt <= (ccnt == C-1)   ? 0 : ccnt + 1;
    end
  end
  assign bus.fetch_done_i = (fcnt == 3*C-1);
  assign bus.core_done_i  = (ccnt == C-1);

  // Expected schedule, indexed by cycle after the start edge.
  bit             v  [MAXC];
  logic [OW-1:0]  ev [MAXC];
  int             len;
  int             fetch_first [NP];
  int             core_first  [NP];

  function automatic logic [OW-1:0] obs();
    return {bus.busy_o, bus.mem_req_o, bus.fetch_en_o, bus.core_en_o,
            bus.done_o, bus.err_o, bus.row_idx_o};
  endfunction

  function automatic logic [OW-1:0] mk(bit busy, bit req, bit fen, bit core,
                                       bit done, bit err, int row);
    return {busy, req, fen, core, done, err, RW'(row)};
  endfunction

  // mode 0: always valid, 1: 1,0,0,1 pattern, 2: random (stall runs capped at 3).
  task automatic build(input int mode);
    int k, cnt, zrun;
    zrun = 0;
    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0:       v[i] = 1'b1;
        1:       v[i] = (i % 4 == 0) || (i % 4 == 3);
        default: v[i] = bit'($urandom_range(0, 1));
      endcase
      if (zrun >= 3) v[i] = 1'b1;
      zrun = v[i] ? 0 : zrun + 1;
    end
    k = 0;
    for (int p = 0; p < NP; p++) begin
      cnt = 0;
      fetch_first[p] = k;
      while (cnt < 3*C) begin
        ev[k] = mk(1, 1, v[k], 0, 0, 0, p);
        if (v[k]) cnt++;
        k++;
      end
      core_first[p] = k;
      for (int c = 0; c < C; c++) begin
        ev[k] = mk(1, 0, 0, 1, 0, 0, p);
        k++;
      end
      ev[k] = mk(1, 0, 0, 0, 0, 0, p);
      k++;
    end
    ev[k] = mk(1, 0, 0, 0, 1, 0, NP-1);
    k++;
    for (int t = 0; t < 4; t++) begin
      ev[k] = mk(0, 0, 0, 0, 0, 0, NP-1);
      k++;
    end
    len = k;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (obs() !== mk(0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_async actual=%h required=%h", obs(), mk(0,0,0,0,0,0,0));
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== mk(0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_idle actual=%h required=%h", obs(), mk(0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nostall();
    int dones;
    dones = 0;
    build(0);
    do_start();
    for (int k = 0; k < len; k++) begin
      bus.mem_valid_i = v[k];
      @(negedge clk);
      if (bus.done_o) begin
        dones++;
        checks++;
        if (k != 51) begin
          errors++;
          $display("FAIL nostall_done_cycle actual=%0d required=51", k);
        end
      end
      checks++;
      if (obs() !== ev[k]) begin
        errors++;
        $display("FAIL nostall k=%0d actual=%h required=%h", k, obs(), ev[k]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL nostall_done_count actual=%0d required=1", dones);
    end
  endtask

  task automatic test_stall_pattern();
    int fens [NP];
    build(1);
    for (int p = 0; p < NP; p++) fens[p] = 0;
    do_start();
    for (int k = 0; k < len; k++) begin
      bus.mem_valid_i = v[k];
      @(negedge clk);
      for (int p = 0; p < NP; p++)
        if (k >= fetch_first[p] && k < core_first[p] && bus.fetch_en_o) fens[p]++;
      checks++;
      if (obs() !== ev[k]) begin
        errors++;
        $display("FAIL stall_pattern k=%0d actual=%h required=%h", k, obs(), ev[k]);
      end
      @(posedge clk); #1;
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (fens[p] != 3*C) begin
        errors++;
        $display("FAIL stall_fetch_count pass=%0d actual=%0d required=%0d", p, fens[p], 3*C);
      end
    end
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 3; rep++) begin
      build(2);
      do_start();
      for (int k = 0; k < len; k++) begin
        bus.mem_valid_i = v[k];
        @(negedge clk);
        checks++;
        if (obs() !== ev[k]) begin
          errors++;
          $display("FAIL random rep=%0d k=%0d actual=%h required=%h", rep, k, obs(), ev[k]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    build(2);
    do_start();
    for (int k = 0; k < len; k++) begin
      bus.mem_valid_i = v[k];
      bus.start_i     = (k == core_first[1]);
      @(negedge clk);
      if (bus.done_o) dones++;
      checks++;
      if (obs() !== ev[k]) begin
        errors++;
        $display("FAIL start_ignored k=%0d actual=%h required=%h", k, obs(), ev[k]);
      end
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL start_ignored_done_count actual=%0d required=1", dones);
    end
  endtask

  task automatic test_abort();
    int ab_k;
    build(1);
    ab_k = fetch_first[1] + 2;
    do_start();
    for (int k = 0; k <= ab_k; k++) begin
      bus.mem_valid_i = v[k];
      bus.abort_i     = (k == ab_k);
      @(negedge clk);
      checks++;
      if (obs() !== ev[k]) begin
        errors++;
        $display("FAIL abort_pre k=%0d actual=%h required=%h", k, obs(), ev[k]);
      end
      @(posedge clk); #1;
    end
    bus.abort_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.mem_valid_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs() !== mk(0,0,0,0,0,0,0)) begin
        errors++;
        $display("FAIL abort_idle k=%0d actual=%h required=%h", k, obs(), mk(0,0,0,0,0,0,0));
      end
      @(posedge clk); #1;
    end
    pp_clr = 1'b1;
    @(posedge clk); #1;
    pp_clr = 1'b0;
  endtask

  task automatic test_async_rst();
    int rk;
    build(0);
    rk = core_first[0] + 1;
    do_start();
    for (int k = 0; k <= rk; k++) begin
      bus.mem_valid_i = v[k];
      @(negedge clk);
      checks++;
      if (obs() !== ev[k]) begin
        errors++;
        $display("FAIL async_pre k=%0d actual=%h required=%h", k, obs(), ev[k]);
      end
      if (k < rk) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== mk(0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL async_rst actual=%h required=%h", obs(), mk(0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== mk(0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL async_rst_after actual=%h required=%h", obs(), mk(0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
  endtask

`ifdef FILTER_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int            stall;
    logic [OW-1:0] e;
    bus.mem_valid_i = 1'b0;
    do_start();
    stall = 0;
    for (int k = 0; k < TO + 4; k++) begin
      bus.mem_valid_i = (stall >= TO) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      e = (stall >= TO) ? mk(1,0,0,0,0,1,0) : mk(1,1,0,0,0,0,0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL timeout k=%0d actual=%h required=%h", k, obs(), e);
      end
      stall++;
      @(posedge clk); #1;
    end
    bus.mem_valid_i = 1'b0;
    bus.abort_i     = 1'b1;
    @(posedge clk); #1;
    bus.abort_i     = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== mk(0,0,0,0,0,1,0)) begin
      errors++;
      $display("FAIL timeout_abort actual=%h required=%h", obs(), mk(0,0,0,0,0,1,0));
    end
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    checks++;
    if (obs() !== mk(1,1,0,0,0,0,0)) begin
      errors++;
      $display("FAIL timeout_clear actual=%h required=%h", obs(), mk(1,1,0,0,0,0,0));
    end
    @(posedge clk); #1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    pp_clr = 1'b1;
    @(posedge clk); #1;
    pp_clr = 1'b0;
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    pp_clr          = 1'b0;
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.mem_valid_i = 1'b0;
    test_reset();
    test_nostall();
    test_stall_pattern();
    test_random();
    test_start_ignored();
    test_abort();
    test_async_rst();
`ifdef FILTER_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
